// File: rtl/ccff_bitstream_loader.sv
// ccff_bitstream_loader
// Takes bitstream words from a valid/ready source and shifts them MSB-first
// onto the configuration chain head. It also produces a per-cycle shift enable
// that drives the external prog_clk gate. Fabric I/O stays isolated (isol_n=0)
// until every chain bit has been loaded. A stall timeout flags a starved source.
// Optional feature macro: CCFF_READBACK_EN. When it is defined, the bits that
// leave through ccff_tail are collected into words on rb_data/rb_valid.
module ccff_bitstream_loader #(
  parameter int CHAIN_LEN = 512,
  parameter int WORD_W    = 32,
  parameter int TIMEOUT   = 1024
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic [WORD_W-1:0] bs_data,
  input  logic              bs_valid,
  output logic              bs_ready,
  output logic              ccff_head,
  output logic              ccff_clk_en,
  input  logic              ccff_tail,
  output logic              isol_n,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef CCFF_READBACK_EN
  ,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid
`endif
);

  localparam int BCW = $clog2(CHAIN_LEN + 1);
  localparam int WCW = $clog2(WORD_W);
  localparam int SCW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [BCW-1:0] LAST_BIT   = BCW'(CHAIN_LEN - 1);
  localparam logic [WCW-1:0] LAST_WBIT  = WCW'(WORD_W - 1);
  localparam logic [SCW-1:0] STALL_LAST = SCW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE,
    S_ERROR
  } state_t;

  state_t            r_state;
  logic              r_head;
  logic              r_clk_en;
  logic              r_isol_n;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic [BCW-1:0]    r_bit_cnt;
  logic [WCW-1:0]    r_wbit;
  logic [SCW-1:0]    r_stall_cnt;
  logic [WORD_W-1:0] r_sreg;

  logic w_accept;
  logic w_start_ok;

  assign bs_ready    = (r_state == S_LOAD);
  assign w_accept    = (r_state == S_LOAD) && bs_valid;
  // A start request is only honoured while no load is in flight.
  assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_DONE) ||
                                 (r_state == S_ERROR));

  assign ccff_head   = r_head;
  assign ccff_clk_en = r_clk_en;
  assign isol_n      = r_isol_n;
  assign busy        = r_busy;
  assign done        = r_done;
  assign err         = r_err;

  // Control FSM: word handshake, bit/word/stall counting and registered status.
  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      r_state     <= S_IDLE;
      r_head      <= 1'b0;
      r_clk_en    <= 1'b0;
      r_isol_n    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_bit_cnt   <= '0;
      r_wbit      <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_clk_en <= 1'b0;
      unique case (r_state)
        S_LOAD: begin
          if (bs_valid) begin
            r_state     <= S_SHIFT;
            r_stall_cnt <= '0;
          end else begin
            if (r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 1'b1;
            if ((TIMEOUT != 0) && (r_stall_cnt == STALL_LAST)) begin
              r_state <= S_ERROR;
              r_err   <= 1'b1;
              r_busy  <= 1'b0;
            end
          end
        end
        S_SHIFT: begin
          r_head    <= r_sreg[WORD_W-1];
          r_clk_en  <= 1'b1;
          r_bit_cnt <= r_bit_cnt + 1'b1;
          if (r_bit_cnt == LAST_BIT) begin
            r_state <= S_DONE;
          end else if (r_wbit == LAST_WBIT) begin
            r_state <= S_LOAD;
            r_wbit  <= '0;
          end else begin
            r_wbit <= r_wbit + 1'b1;
          end
        end
        // Status flips on the edge after the final bit, together with the
        // enable dropping, so the chain is never released while still shifting.
        S_DONE: begin
          r_done   <= 1'b1;
          r_isol_n <= 1'b1;
          r_busy   <= 1'b0;
        end
        default: begin
        end
      endcase
      if (w_start_ok) begin
        r_state     <= S_LOAD;
        r_done      <= 1'b0;
        r_err       <= 1'b0;
        r_isol_n    <= 1'b0;
        r_busy      <= 1'b1;
        r_bit_cnt   <= '0;
        r_wbit      <= '0;
        r_stall_cnt <= '0;
      end
    end
  end

  // Shift register: capture the accepted word, then move it up one bit per SHIFT cycle.
  always_ff @(posedge prog_clk) begin
    if (w_accept) begin
      r_sreg <= bs_data;
    end else if (r_state == S_SHIFT) begin
      r_sreg <= {r_sreg[WORD_W-2:0], 1'b0};
    end
  end

`ifdef CCFF_READBACK_EN
  localparam logic [BCW-1:0] CHAIN_END = BCW'(CHAIN_LEN);

  logic [WORD_W-1:0] r_rb_acc;
  logic [WORD_W-1:0] r_rb_data;
  logic [WCW-1:0]    r_rb_idx;
  logic              r_rb_valid;
  logic [WORD_W-1:0] w_rb_acc_nxt;

  // Place the incoming tail bit at its MSB-first position in the current word.
  always_comb begin
    w_rb_acc_nxt = r_rb_acc;
    w_rb_acc_nxt[LAST_WBIT - r_rb_idx] = ccff_tail;
  end

  // Readback collector: one tail sample per chain shift, flushed per word or at the chain end.
  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      r_rb_acc   <= '0;
      r_rb_data  <= '0;
      r_rb_idx   <= '0;
      r_rb_valid <= 1'b0;
    end else begin
      r_rb_valid <= 1'b0;
      if (r_clk_en) begin
        // r_bit_cnt already counts the bit being shifted out on this edge.
        if ((r_rb_idx == LAST_WBIT) || (r_bit_cnt == CHAIN_END)) begin
          r_rb_data  <= w_rb_acc_nxt;
          r_rb_valid <= 1'b1;
          r_rb_acc   <= '0;
          r_rb_idx   <= '0;
        end else begin
          r_rb_acc <= w_rb_acc_nxt;
          r_rb_idx <= r_rb_idx + 1'b1;
        end
      end else if (w_start_ok) begin
        r_rb_acc <= '0;
        r_rb_idx <= '0;
      end
    end
  end

  assign rb_data  = r_rb_data;
  assign rb_valid = r_rb_valid;
`else
  logic w_unused_tail;
  assign w_unused_tail = ccff_tail;
`endif

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Testbench for ccff_bitstream_loader: directed and randomized loads
// checked against a word-list model of the expected chain contents.
module tb_ccff_bitstream_loader;

  localparam int CL = 20;
  localparam int W  = 8;
  localparam int TO = 8;
  localparam int NW = (CL + W - 1) / W;
  localparam logic [CL-1:0] TAIL_PAT = {8'h5A, 8'h81, 4'h9};

  logic         clk = 1'b0;
  logic         prog_reset;
  logic         start;
  logic         bs_valid;
  logic [W-1:0] bs_data;
  logic         ccff_tail = 1'b0;
  logic         bs_ready, ccff_head, ccff_clk_en, isol_n, busy, done, err;
`ifdef CCFF_READBACK_EN
  logic [W-1:0] rb_data;
  logic         rb_valid;
`endif

  int n_chk = 0;
  int n_err = 0;

  logic [W-1:0] wq[NW];
  int           stall[NW];

  // monitor state
  logic [CL-1:0] obs_vec;
  int            obs_cnt, first_en, last_en, gap_runs, rdy_cnt;
  bit            done_seen, done_align, prev_en;
  logic [W-1:0]  rb_q[$];
  int            tail_idx;

  always #5 clk = ~clk;

  ccff_bitstream_loader #(
    .CHAIN_LEN(CL),
    .WORD_W   (W),
    .TIMEOUT  (TO)
  ) dut (
    .prog_clk   (clk),
    .prog_reset (prog_reset),
    .start      (start),
    .bs_data    (bs_data),
    .bs_valid   (bs_valid),
    .bs_ready   (bs_ready),
    .ccff_head  (ccff_head),
    .ccff_clk_en(ccff_clk_en),
    .ccff_tail  (ccff_tail),
    .isol_n     (isol_n),
    .busy       (busy),
    .done       (done),
    .err        (err)
`ifdef CCFF_READBACK_EN
    ,
    .rb_data    (rb_data),
    .rb_valid   (rb_valid)
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic mon_clear();
    obs_vec    = '0;
    obs_cnt    = 0;
    first_en   = -1;
    last_en    = 0;
    gap_runs   = 0;
    rdy_cnt    = 0;
    done_seen  = 1'b0;
    done_align = 1'b0;
    prev_en    = 1'b0;
    tail_idx   = 0;
    rb_q.delete();
  endtask

  // Observe outputs mid-cycle; also supplies the chain tail bit for the next edge.
  int ncyc = 0;
  always @(negedge clk) begin
    if (ccff_clk_en) begin
      obs_vec = {obs_vec[CL-2:0], ccff_head};
      obs_cnt++;
      if (first_en < 0) first_en = ncyc;
      last_en = ncyc;
      if (!prev_en && obs_cnt > 1) gap_runs++;
    end
    if (bs_ready) rdy_cnt++;
    if (done && !done_seen) begin
      done_seen  = 1'b1;
      done_align = prev_en && !ccff_clk_en;
    end
    prev_en = ccff_clk_en;
    ncyc++;
`ifdef CCFF_READBACK_EN
    if (rb_valid) rb_q.push_back(rb_data);
    if (ccff_clk_en && tail_idx < CL) begin
      ccff_tail = TAIL_PAT[CL-1-tail_idx];
      tail_idx++;
    end
`else
    ccff_tail = 1'($urandom_range(0, 1));
`endif
  end

  // Chain contents = words concatenated MSB-first, truncated to the chain length.
  function automatic logic [CL-1:0] expect_bits();
    logic [CL-1:0] v;
    int k;
    v = '0;
    k = 0;
    for (int i = 0; i < NW; i++)
      for (int b = W - 1; b >= 0; b--)
        if (k < CL) begin
          v[CL-1-k] = wq[i][b];
          k++;
        end
    return v;
  endfunction

  task automatic run_load(input bit rnd_start);
    int g;
    int span_exp;
    int rdy_exp;
    logic [W-1:0] rb_exp[3];
    rb_exp = '{8'h5A, 8'h81, 8'h90};
    step(); mon_clear(); start = 1'b1;
    step(); start = 1'b0;
    check_val("start_done", done, 1'b0);
    check_val("start_err", err, 1'b0);
    check_val("start_isol", isol_n, 1'b0);
    check_val("start_busy", busy, 1'b1);
    for (int i = 0; i < NW; i++) begin
      bs_valid = 1'b0;
      g = 0;
      while (!bs_ready && g < 64) begin
        if (rnd_start) start = 1'($urandom_range(0, 1));
        step();
        g++;
      end
      check_val("ready_wait", (g < 64), 1'b1);
      repeat (stall[i]) begin
        if (rnd_start) start = 1'($urandom_range(0, 1));
        step();
      end
      bs_valid = 1'b1;
      bs_data  = wq[i];
      step();
      bs_valid = 1'b0;
      start    = 1'b0;
    end
    g = 0;
    while (!done && g < 64) begin
      step();
      g++;
    end
    check_val("done_wait", (g < 64), 1'b1);
    check_val("fin_isol", isol_n, 1'b1);
    check_val("fin_busy", busy, 1'b0);
    check_val("fin_err", err, 1'b0);
    check_val("fin_en", ccff_clk_en, 1'b0);
    repeat (3) step();
    span_exp = CL;
    rdy_exp  = NW;
    for (int i = 0; i < NW; i++) begin
      rdy_exp += stall[i];
      if (i > 0) span_exp += 1 + stall[i];
    end
    check_val("bits", obs_vec, expect_bits());
    check_val("en_cycles", obs_cnt, CL);
    check_val("gap_runs", gap_runs, NW - 1);
    check_val("en_span", last_en - first_en + 1, span_exp);
    check_val("ready_cycles", rdy_cnt, rdy_exp);
    check_val("done_align", done_align, 1'b1);
    check_val("done_hold", done, 1'b1);
`ifdef CCFF_READBACK_EN
    check_val("rb_pulses", rb_q.size(), 3);
    for (int i = 0; i < 3 && i < rb_q.size(); i++)
      check_val($sformatf("rb_word%0d", i), rb_q[i], rb_exp[i]);
`endif
  endtask

  task automatic timeout_case();
    int g;
    int cnt;
    step(); mon_clear(); start = 1'b1;
    step(); start = 1'b0;
    bs_valid = 1'b1;
    bs_data  = 8'h96;
    step();
    bs_valid = 1'b0;
    g = 0;
    while (!bs_ready && g < 64) begin
      step();
      g++;
    end
    check_val("to_ready_wait", (g < 64), 1'b1);
    cnt = 0;
    while (!err && cnt < 64) begin
      step();
      cnt++;
    end
    check_val("to_cycles", cnt, TO);
    check_val("to_isol", isol_n, 1'b0);
    check_val("to_done", done, 1'b0);
    check_val("to_busy", busy, 1'b0);
    check_val("to_ready", bs_ready, 1'b0);
    check_val("to_en", ccff_clk_en, 1'b0);
    repeat (3) step();
    check_val("to_err_sticky", err, 1'b1);
  endtask

  task automatic reset_case();
    int g;
    step(); mon_clear(); start = 1'b1;
    step(); start = 1'b0;
    bs_valid = 1'b1;
    bs_data  = 8'h00;
    step();
    bs_valid = 1'b0;
    g = 0;
    while (!bs_ready && g < 64) begin
      step();
      g++;
    end
    bs_valid = 1'b1;
    bs_data  = 8'hFF;
    step();
    bs_valid = 1'b0;
    step();
    check_val("pre_rst_en", ccff_clk_en, 1'b1);
    check_val("pre_rst_head", ccff_head, 1'b1);
    #2 prog_reset = 1'b1;
    #1;
    check_val("arst_head", ccff_head, 1'b0);
    check_val("arst_en", ccff_clk_en, 1'b0);
    check_val("arst_ready", bs_ready, 1'b0);
    check_val("arst_isol", isol_n, 1'b0);
    check_val("arst_busy", busy, 1'b0);
    check_val("arst_done", done, 1'b0);
    check_val("arst_err", err, 1'b0);
    start = 1'b1;
    step();
    step();
    check_val("rst_start_busy", busy, 1'b0);
    check_val("rst_start_ready", bs_ready, 1'b0);
    prog_reset = 1'b0;
    start = 1'b0;
    step();
    check_val("post_rst_ready", bs_ready, 1'b0);
    check_val("post_rst_busy", busy, 1'b0);
    for (int i = 0; i < NW; i++) begin
      wq[i]    = 8'($urandom_range(0, 255));
      stall[i] = 0;
    end
    run_load(1'b0);
  endtask

  initial begin
    prog_reset = 1'b1;
    start      = 1'b0;
    bs_valid   = 1'b0;
    bs_data    = '0;
    mon_clear();
    step();
    step();
    check_val("rst_head", ccff_head, 1'b0);
    check_val("rst_en", ccff_clk_en, 1'b0);
    check_val("rst_ready", bs_ready, 1'b0);
    check_val("rst_isol", isol_n, 1'b0);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_done", done, 1'b0);
    check_val("rst_err", err, 1'b0);
    prog_reset = 1'b0;
    step();
    check_val("idle_ready", bs_ready, 1'b0);

    wq    = '{8'hA5, 8'h3C, 8'hF0};
    stall = '{0, 0, 0};
    run_load(1'b0);

    stall = '{0, 5, 0};
    run_load(1'b0);

    timeout_case();
    wq    = '{8'h12, 8'hEF, 8'h7C};
    stall = '{1, 0, 2};
    run_load(1'b0);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NW; i++) begin
        wq[i]    = 8'($urandom_range(0, 255));
        stall[i] = $urandom_range(0, TO - 1);
      end
      run_load(1'b1);
    end

    reset_case();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not reach the summary");
    $fatal(1);
  end

endmodule
